// File: rtl/adder_pkg.sv
// Shared definitions for the multi-cycle adder: FSM state type, default
// geometry and the geometry check used at elaboration.
package adder_pkg;

    // Default geometry: a 16-bit add done four bits per clock.
    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    // Controller states. DONE marks the cycle after the last chunk add.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } adder_state_t;

    // A geometry is usable only if CHUNK is in 1..WIDTH and tiles WIDTH exactly.
    function automatic bit chunk_divides_width(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple adder. Besides the chunk carry-out it
// exports the carry into its top bit, which the top level uses for signed
// overflow on the most significant chunk.
module chunk_adder
    import adder_pkg::*;
#(
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             carry_msb
);

    // carry[i] is the carry into bit i; carry[CHUNK] leaves the chunk.
    logic [CHUNK:0] carry;

    assign carry[0] = cin;

    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_bit
            assign sum[gi]       = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout      = carry[CHUNK];
    assign carry_msb = carry[CHUNK-1];

endmodule

// File: rtl/multi_cycle_adder.sv
// Multi-cycle adder: {COUT,S} = A + B + CIN, computed CHUNK bits per clock
// under a START/BUSY/DONE handshake. All outputs come straight from flops.
// Optional feature macro: MULTI_CYCLE_ADDER_OVF_EN adds the OVF port
// (signed overflow, registered with the final chunk).
module multi_cycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] S,
    output logic             COUT
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    // Reject geometries where the chunks do not tile the operand exactly.
    generate
        if (!chunk_divides_width(WIDTH, CHUNK)) begin : g_geometry_check
            $error("multi_cycle_adder: CHUNK=%0d must be in 1..WIDTH and divide WIDTH=%0d",
                   CHUNK, WIDTH);
        end
    endgenerate

    // Note: the port DONE shadows the enum literal of the same name, so the
    // state literal is always written package-qualified below.
    adder_state_t     state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] s_q,     s_d;
    logic             cout_q,  cout_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    logic             ovf_q,   ovf_d;
`endif

    // Chunk slices of the latched operands and the S image with the active
    // chunk replaced by the fresh chunk sum.
    logic [CHUNK-1:0] a_chunks [NCHUNK];
    logic [CHUNK-1:0] b_chunks [NCHUNK];
    logic [CHUNK-1:0] a_sel;
    logic [CHUNK-1:0] b_sel;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic [WIDTH-1:0] s_write;

    generate
        for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_slice
            assign a_chunks[gi] = a_q[gi*CHUNK +: CHUNK];
            assign b_chunks[gi] = b_q[gi*CHUNK +: CHUNK];
            assign s_write[gi*CHUNK +: CHUNK] =
                (idx_q == IDX_W'(gi)) ? chunk_sum : s_q[gi*CHUNK +: CHUNK];
        end
    endgenerate

    assign a_sel = a_chunks[idx_q];
    assign b_sel = b_chunks[idx_q];

`ifdef MULTI_CYCLE_ADDER_OVF_EN
    logic chunk_carry_msb;
`else
    // Carry into the MSB only matters for overflow, which this build omits.
    logic chunk_carry_msb_unused;
`endif

    chunk_adder #(
        .CHUNK     (CHUNK)
    ) u_chunk_adder (
        .a         (a_sel),
        .b         (b_sel),
        .cin       (carry_q),
        .sum       (chunk_sum),
        .cout      (chunk_cout),
`ifdef MULTI_CYCLE_ADDER_OVF_EN
        .carry_msb (chunk_carry_msb)
`else
        .carry_msb (chunk_carry_msb_unused)
`endif
    );

    // Next-state logic: accept in IDLE, one chunk per ADD cycle, then a
    // DONE cycle whose end raises the registered DONE pulse.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        busy_d  = busy_q;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        // BUSY covers the DONE pulse cycle and drops right after it,
        // unless a new request is accepted on that same edge.
        if (done_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = CIN;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ADD;
                end
            end
            ADD: begin
                s_d     = s_write;
                carry_d = chunk_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = chunk_cout;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
                    ovf_d   = chunk_carry_msb ^ chunk_cout;
`endif
                    state_d = adder_pkg::DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            adder_pkg::DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any add in flight.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign BUSY = busy_q;
    assign DONE = done_q;
    assign S    = s_q;
    assign COUT = cout_q;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Scoreboard bench for multi_cycle_adder (WIDTH=16, CHUNK=4). Stimulus pushes
// hand-computed results; a negedge monitor pops and compares on every DONE.
// Build with MULTI_CYCLE_ADDER_OVF_EN to also check OVF.
`timescale 1ns/1ps
module tb_multi_cycle_adder;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        cin   = 1'b0;
    logic [15:0] a     = '0;
    logic [15:0] b     = '0;
    logic        busy;
    logic        done;
    logic        cout;
    logic [15:0] s;
`ifdef MULTI_CYCLE_ADDER_OVF_EN
    logic        ovf;
`endif

    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } vec_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    always #5 clk = ~clk;

    multi_cycle_adder #(
        .WIDTH (16),
        .CHUNK (4)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .START (start),
        .A     (a),
        .B     (b),
        .CIN   (cin),
        .BUSY  (busy),
        .DONE  (done),
        .S     (s),
        .COUT  (cout)
`ifdef MULTI_CYCLE_ADDER_OVF_EN
        ,
        .OVF   (ovf)
`endif
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Monitor: every DONE pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                e = exp_q.pop_front();
                txn++;
                check("sum", 32'(s), 32'(e.s));
                check("cout", 32'(cout), 32'(e.cout));
`ifdef MULTI_CYCLE_ADDER_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
                $display("txn %0d: S=0x%04h COUT=%0b OVF=%0b (want 0x%04h %0b %0b)",
                         txn, s, cout, ovf, e.s, e.cout, e.ovf);
`else
                $display("txn %0d: S=0x%04h COUT=%0b (want 0x%04h %0b)",
                         txn, s, cout, e.s, e.cout);
`endif
            end
        end
    end

    // Drive one request; returns at the negedge just after the accept edge,
    // with the inputs scrambled to show later changes have no effect.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic icin,
                         input bit push, input logic [15:0] es, input logic ec,
                         input logic eo);
        exp_t e;
        @(negedge clk);
        a = ia;
        b = ib;
        cin = icin;
        start = 1'b1;
        if (push) begin
            e.s = es;
            e.cout = ec;
            e.ovf = eo;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a = ~ia;
        b = ~ib;
        cin = ~icin;
    endtask

    // Wait (bounded) for DONE; edges0 = clock edges already elapsed since accept.
    task automatic wait_done(input string nm, input int edges0, input int exp_edges,
                             output int busy_cnt);
        int edges = edges0;
        busy_cnt = busy ? 1 : 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check({nm, "_latency"}, 32'(edges), 32'(exp_edges));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [6];
        int   bc;
        int   done_cnt;

        vecs[0] = '{a: 16'hFFFF, b: 16'h0001, cin: 1'b0, s: 16'h0000, cout: 1'b1, ovf: 1'b0};
        vecs[1] = '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, s: 16'h0000, cout: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 16'h1234, b: 16'h4321, cin: 1'b1, s: 16'h5556, cout: 1'b0, ovf: 1'b0};
        vecs[3] = '{a: 16'h7FFF, b: 16'h0001, cin: 1'b0, s: 16'h8000, cout: 1'b0, ovf: 1'b1};
        vecs[4] = '{a: 16'h8000, b: 16'hFFFF, cin: 1'b0, s: 16'h7FFF, cout: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 16'h0005, b: 16'hFFFB, cin: 1'b0, s: 16'h0000, cout: 1'b1, ovf: 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_s", 32'(s), 32'(0));
        check("rst_cout", 32'(cout), 32'(0));
`ifdef MULTI_CYCLE_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf), 32'(0));
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'(0));

        // Basic add, latency and BUSY window
        issue(16'h1234, 16'h4321, 1'b0, 1'b1, 16'h5555, 1'b0, 1'b0);
        check("t1_busy_after_accept", 32'(busy), 32'(1));
        wait_done("t1", 0, 5, bc);
        check("t1_busy_cycles", 32'(bc), 32'(6));
        @(negedge clk);
        check("t1_busy_fall", 32'(busy), 32'(0));
        check("t1_done_one_cycle", 32'(done), 32'(0));
        check("t1_s_hold", 32'(s), 32'(16'h5555));

        // Carry propagation and overflow vectors
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, vecs[i].s, vecs[i].cout, vecs[i].ovf);
            wait_done($sformatf("vec%0d", i), 0, 5, bc);
        end
        @(negedge clk);

        // START during ADD ignored; START held through DONE re-accepts after it
        issue(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
        @(negedge clk);
        a = 16'hAAAA;
        b = 16'h5555;
        cin = 1'b0;
        start = 1'b1;
        exp_q.push_back('{s: 16'hFFFF, cout: 1'b0, ovf: 1'b0});
        wait_done("t3a", 1, 5, bc);
        @(negedge clk);
        check("t3_reaccept_busy", 32'(busy), 32'(1));
        check("t3_no_second_done", 32'(done), 32'(0));
        start = 1'b0;
        a = 16'h0000;
        b = 16'h0000;
        wait_done("t3b", 0, 5, bc);
        @(negedge clk);

        // Reset during the third ADD cycle discards the operation
        issue(16'h00FF, 16'h0101, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t4_busy", 32'(busy), 32'(0));
        check("t4_done", 32'(done), 32'(0));
        check("t4_s", 32'(s), 32'(0));
        check("t4_cout", 32'(cout), 32'(0));
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("t4_no_done_pulse", 32'(done_cnt), 32'(0));
        issue(16'h0003, 16'h0004, 1'b0, 1'b1, 16'h0007, 1'b0, 1'b0);
        wait_done("t4", 0, 5, bc);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
